iter_shift_unit: RTL and testbench
==================================

Name: iter_shift_unit

Overview:
- Multi-cycle shift sequencer for the ALU shift instructions (SLL/SRL/SRA and their variable forms).
- Accepts an operand, a 5-bit shift amount and a mode, then applies repeated fixed-distance shift steps to reach the full amount.
- Uses a start/done handshake and sits between the decode/issue stage and the ALU result mux.
- Mode encoding matches the fixed-distance shift stage: 00 logical right, 01 left, 10 arithmetic right, 11 zero.

Parameters:
BIG_STEP, 4, bulk shift distance per cycle; legal values 2 or 4.
WIDTH, 32, datapath width; fixed at 32 for this core.

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
start  input  1  request; accepted only when busy=0
op_a  input  32  operand to shift
shamt  input  5  shift amount, 0..31
mode  input  2  00 SRL, 01 SLL, 10 SRA, 11 result forced to 0
busy  output  1  high while the SHIFT state is active
done  output  1  single-cycle pulse; result is valid from this cycle on
result  output  32  final shifted value; held until the next done

Behaviour:
- Reset (async, rst_n=0):
  - state=IDLE; busy=0, done=0, result=0; internal work register and counter cleared.
  - Reset asserted mid-operation aborts it: no done pulse, result=0.
- States are IDLE, SHIFT and DONE.
- IDLE or DONE, start=1 (accepted):
  - Latch op_a into work, mode into mode_q, shamt into rem (5 bits).
  - If mode=11, or if shamt=0: next state is DONE.
  - Otherwise next state is SHIFT.
- SHIFT, one step per cycle:
  - If rem>=BIG_STEP: shift work by BIG_STEP and set rem -= BIG_STEP.
  - Otherwise: shift work by 1 and set rem -= 1.
  - When rem becomes 0, next state is DONE.
- Step semantics, for a shift of n:
  - SRL: zero-fill from the MSB side.
  - SLL: zero-fill from the LSB side.
  - SRA: the top n bits take the current work[31]. Sign is preserved across steps because each step keeps the MSB.
- DONE (exactly one cycle):
  - done=1.
  - result loads from the final value on the transition into DONE: work, or 0 if mode_q=11.
  - Next state is IDLE, unless start=1, in which case the new request is accepted and the state moves to SHIFT or DONE as above.
- Latency:
  - k = shamt/BIG_STEP + shamt%BIG_STEP shift cycles.
  - Start accepted in cycle N gives SHIFT in cycles N+1..N+k and done in cycle N+k+1.
  - shamt=0 or mode=11 gives done at N+1.
  - Worst case with BIG_STEP=4, shamt=31: k=10, done at N+11.
- busy=1 exactly in SHIFT cycles. start while busy=1 is ignored, with no effect on any latched value.
- result changes only on entry to DONE. It is stable between done pulses, including while a new operation is in SHIFT.
- Inputs are sampled only in the accept cycle. Changes to op_a, shamt or mode after that cycle have no effect.

Decomposition:
- Shared package cpu_pkg holds:
  - shift mode constants SH_SRL=2'b00, SH_SLL=2'b01, SH_SRA=2'b10, SH_ZERO=2'b11;
  - state encoding (IDLE, SHIFT, DONE);
  - WIDTH default.
- One combinational sub-module, shift_step (inputs: work, mode_q, a 1-bit selector between BIG_STEP and 1; output: next work), instantiated once.
- The FSM, counter and registers stay in iter_shift_unit.

Test Plan:
1. SLL, op_a=0x0000_0001, shamt=31, start at cycle N -> busy high for cycles N+1..N+10, done at N+11, result=0x8000_0000.
2. SRA, op_a=0x8000_0000, shamt=5 -> k=2, done at N+3, result=0xFC00_0000. Repeat with op_a=0x7000_0000 -> result=0x0380_0000.
3. SRL, op_a=0xF000_000F, shamt=4 -> k=1, done at N+2, result=0x0F00_0000. Repeat with shamt=3 -> k=3, result=0x1E00_0001.
4. SLL, op_a=0x1234_5678, shamt=0 -> no busy, done at N+1, result=0x1234_5678. Then mode=11, op_a=0xFFFF_FFFF, shamt=7 -> done at N+1, result=0.
5. SLL, op_a=1, shamt=8; pulse start again at N+1 with op_a=0xFFFF_FFFF -> second start ignored, result=0x0000_0100. Then start a new op, assert rst_n=0 at N+1 -> busy=0, done=0, result=0 immediately; after release, a fresh SRL 0x80 by 7 -> result=0x1.
6. Back-to-back: start held high in the DONE cycle with SLL 0x3 by 2 -> accepted, done 2 cycles later with result=0xC. The previous result holds until then.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared ALU definitions: shift mode encoding, shift sequencer states, datapath width.
package cpu_pkg;
  localparam int WIDTH_DEF = 32;

  localparam logic [1:0] SH_SRL  = 2'b00;
  localparam logic [1:0] SH_SLL  = 2'b01;
  localparam logic [1:0] SH_SRA  = 2'b10;
  localparam logic [1:0] SH_ZERO = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } sh_state_t;
endpackage

// File: rtl/shift_step.sv
// One fixed-distance shift step: either BIG_STEP or 1 position, per mode.
module shift_step
  import cpu_pkg::*;
#(
  parameter int WIDTH    = WIDTH_DEF,
  parameter int BIG_STEP = 4
) (
  input  logic [WIDTH-1:0] work,
  input  logic [1:0]       mode_q,
  input  logic             big,
  output logic [WIDTH-1:0] nxt
);
  always_comb begin
    nxt = '0;
    if (big) begin
      case (mode_q)
        SH_SRL:  nxt = {{BIG_STEP{1'b0}}, work[WIDTH-1:BIG_STEP]};
        SH_SLL:  nxt = {work[WIDTH-1-BIG_STEP:0], {BIG_STEP{1'b0}}};
        SH_SRA:  nxt = {{BIG_STEP{work[WIDTH-1]}}, work[WIDTH-1:BIG_STEP]};
        default: nxt = '0;
      endcase
    end else begin
      case (mode_q)
        SH_SRL:  nxt = {1'b0, work[WIDTH-1:1]};
        SH_SLL:  nxt = {work[WIDTH-2:0], 1'b0};
        SH_SRA:  nxt = {work[WIDTH-1], work[WIDTH-1:1]};
        default: nxt = '0;
      endcase
    end
  end
endmodule

// File: rtl/iter_shift_unit.sv
// Multi-cycle shift sequencer: bulk BIG_STEP steps, then single steps, start/done handshake.
module iter_shift_unit
  import cpu_pkg::*;
#(
  parameter int BIG_STEP = 4,
  parameter int WIDTH    = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] op_a,
  input  logic [4:0]       shamt,
  input  logic [1:0]       mode,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);
  sh_state_t        state;
  logic [WIDTH-1:0] work;
  logic [WIDTH-1:0] step_nxt;
  logic [1:0]       mode_q;
  logic [4:0]       rem;
  logic             step_big;
  logic [4:0]       step_amt;

  assign step_big = (rem >= 5'(BIG_STEP));
  assign step_amt = step_big ? 5'(BIG_STEP) : 5'd1;

  shift_step #(.WIDTH(WIDTH), .BIG_STEP(BIG_STEP)) u_step (
    .work   (work),
    .mode_q (mode_q),
    .big    (step_big),
    .nxt    (step_nxt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= ST_IDLE;
      busy   <= 1'b0;
      done   <= 1'b0;
      result <= '0;
      work   <= '0;
      mode_q <= SH_SRL;
      rem    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        ST_SHIFT: begin
          work <= step_nxt;
          rem  <= rem - step_amt;
          // last step: publish the shifted value as we enter DONE
          if (rem == step_amt) begin
            state  <= ST_DONE;
            busy   <= 1'b0;
            done   <= 1'b1;
            result <= step_nxt;
          end
        end
        default: begin
          busy <= 1'b0;
          if (start) begin
            work   <= op_a;
            mode_q <= mode;
            rem    <= shamt;
            if (mode == SH_ZERO || shamt == 5'd0) begin
              state  <= ST_DONE;
              done   <= 1'b1;
              result <= (mode == SH_ZERO) ? '0 : op_a;
            end else begin
              state <= ST_SHIFT;
              busy  <= 1'b1;
            end
          end else begin
            state <= ST_IDLE;
          end
        end
      endcase
    end
  end
endmodule

// File: tb/tb_iter_shift_unit.sv
// Randomized + directed bench for iter_shift_unit against a plain-arithmetic shift model.
module tb_iter_shift_unit;
  localparam int BIG = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] op_a = '0;
  logic [4:0]  shamt = '0;
  logic [1:0]  mode = '0;
  logic        busy, done;
  logic [31:0] result;

  int n_chk = 0;
  int n_err = 0;
  logic [31:0] prev_res = '0;

  always #5 clk = ~clk;

  iter_shift_unit #(.BIG_STEP(BIG), .WIDTH(32)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .shamt(shamt),
    .mode(mode), .busy(busy), .done(done), .result(result)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] ref_res(input logic [31:0] a, input int s, input logic [1:0] m);
    logic signed [31:0] sa;
    sa = a;
    case (m)
      2'b00:   return a >> s;
      2'b01:   return a << s;
      2'b10:   return sa >>> s;
      default: return 32'h0;
    endcase
  endfunction

  function automatic int ref_k(input int s, input logic [1:0] m);
    if (m == 2'b11 || s == 0) return 0;
    return s / BIG + s % BIG;
  endfunction

  // Called at a negedge; returns at the negedge of the done cycle (DUT in DONE).
  task automatic run_op(input string tag, input logic [31:0] a, input logic [4:0] s,
                        input logic [1:0] m, input bit poke);
    int k, cyc, nb;
    bit unstable, seen;
    logic [31:0] exp;
    k = ref_k(int'(s), m);
    exp = ref_res(a, int'(s), m);
    op_a = a; shamt = s; mode = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    op_a = $urandom; shamt = 5'($urandom); mode = 2'($urandom);
    nb = 0; unstable = 0; seen = 0;
    for (cyc = 1; cyc <= 40; cyc++) begin
      if (done) begin seen = 1; break; end
      if (busy) nb++;
      if (result !== prev_res) unstable = 1;
      if (poke) begin
        start = (cyc == 1);
        op_a = 32'hFFFF_FFFF;
      end
      @(negedge clk);
    end
    start = 1'b0;
    chk({tag, ".seen"}, 32'(seen), 32'd1);
    chk({tag, ".lat"}, 32'(cyc), 32'(k + 1));
    chk({tag, ".busycnt"}, 32'(nb), 32'(k));
    chk({tag, ".busy@done"}, 32'(busy), 32'd0);
    chk({tag, ".hold"}, 32'(unstable), 32'd0);
    chk({tag, ".res"}, result, exp);
    prev_res = exp;
  endtask

  task automatic idle_after(input string tag);
    @(negedge clk);
    chk({tag, ".pulse"}, 32'(done), 32'd0);
    chk({tag, ".keep"}, result, prev_res);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst.busy", 32'(busy), 32'd0);
    chk("rst.done", 32'(done), 32'd0);
    chk("rst.res", result, 32'd0);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("sll31", 32'h0000_0001, 5'd31, 2'b01, 0); idle_after("sll31");
    chk("sll31.lit", result, 32'h8000_0000);
    run_op("sra5n", 32'h8000_0000, 5'd5, 2'b10, 0); idle_after("sra5n");
    chk("sra5n.lit", result, 32'hFC00_0000);
    run_op("sra5p", 32'h7000_0000, 5'd5, 2'b10, 0); idle_after("sra5p");
    chk("sra5p.lit", result, 32'h0380_0000);
    run_op("srl4", 32'hF000_000F, 5'd4, 2'b00, 0); idle_after("srl4");
    chk("srl4.lit", result, 32'h0F00_0000);
    run_op("srl3", 32'hF000_000F, 5'd3, 2'b00, 0); idle_after("srl3");
    chk("srl3.lit", result, 32'h1E00_0001);
    run_op("sh0", 32'h1234_5678, 5'd0, 2'b01, 0); idle_after("sh0");
    chk("sh0.lit", result, 32'h1234_5678);
    run_op("zero", 32'hFFFF_FFFF, 5'd7, 2'b11, 0); idle_after("zero");
    chk("zero.lit", result, 32'h0);
    run_op("ignore", 32'h0000_0001, 5'd8, 2'b01, 1); idle_after("ignore");
    chk("ignore.lit", result, 32'h0000_0100);

    // reset in the middle of an operation
    op_a = 32'h0000_00F0; shamt = 5'd20; mode = 2'b00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort.busy", 32'(busy), 32'd0);
    chk("abort.done", 32'(done), 32'd0);
    chk("abort.res", result, 32'd0);
    prev_res = '0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("abort.nodone", 32'(done), 32'd0);
    run_op("post", 32'h0000_0080, 5'd7, 2'b00, 0); idle_after("post");
    chk("post.lit", result, 32'h0000_0001);

    // back-to-back: new start issued during the DONE cycle
    run_op("b2b.a", 32'hDEAD_BEEF, 5'd9, 2'b00, 0);
    run_op("b2b.b", 32'h0000_0003, 5'd2, 2'b01, 0);
    chk("b2b.lit", result, 32'h0000_000C);
    idle_after("b2b");

    for (int i = 0; i < 60; i++) begin
      logic [31:0] a;
      logic [4:0] s;
      logic [1:0] m;
      a = $urandom;
      s = 5'($urandom);
      m = 2'($urandom);
      if ($urandom_range(0, 7) == 0) s = 5'd0;
      run_op($sformatf("rnd%0d", i), a, s, m, bit'($urandom_range(0, 1)));
      if ($urandom_range(0, 1) == 1) idle_after($sformatf("rnd%0d", i));
    end
    idle_after("end");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
